imem_port_arbiter: RTL

//  Shares the single instruction-memory port between the core fetch unit and a program loader/debug port.

---
 rtl/types_pkg.sv | 25 ++
 rtl/imem_arb_perf.sv | 41 ++++
 rtl/imem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared instruction-memory types plus the arbiter's state and owner encodings.
//   address_t    : word address of the instruction memory
//   word_t       : memory data word
//   MEM_SIZE     : number of words in the instruction memory
//   arb_state_e  : S_SHARED (fetch has priority) / S_LOCK (port parked for the loader)
//   imem_owner_e : which requester gets the read data returned next cycle
package types_pkg;

   localparam int unsigned MEM_SIZE = 1024;

   typedef logic [15:0] address_t;
   typedef logic [31:0] word_t;

   typedef enum logic [0:0] {
      S_SHARED = 1'b0,
      S_LOCK   = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2
   } imem_owner_e;

endpackage

// File: rtl/imem_arb_perf.sv
// Saturating performance counter bank for the instruction-memory arbiter.
// Only instantiated when IMEM_ARB_PERF_EN is defined.
//   clk, rst_n    : clock, asynchronous active-low reset
//   f_gnt_i       : fetch grant this cycle
//   l_gnt_i       : loader grant this cycle
//   stall_i       : fetch requested but not granted this cycle
//   perf_fetch_o  : number of fetch grants
//   perf_load_o   : number of loader grants
//   perf_stall_o  : number of fetch stall cycles
module imem_arb_perf #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             f_gnt_i,
   input  logic             l_gnt_i,
   input  logic             stall_i,
   output logic [CNT_W-1:0] perf_fetch_o,
   output logic [CNT_W-1:0] perf_load_o,
   output logic [CNT_W-1:0] perf_stall_o
);

   logic [CNT_W-1:0] fetch_q, load_q, stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_q <= '0;
         load_q  <= '0;
         stall_q <= '0;
      end else begin
         if (f_gnt_i && (fetch_q != '1)) fetch_q <= fetch_q + 1'b1;
         if (l_gnt_i && (load_q != '1))  load_q  <= load_q + 1'b1;
         if (stall_i && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      end
   end

   assign perf_fetch_o = fetch_q;
   assign perf_load_o  = load_q;
   assign perf_stall_o = stall_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between the core fetch unit and a
// program loader/debug port. Fetch has priority; a loader denied STARVE_LIMIT
// consecutive cycles is forced a grant. A granted loader access with l_lock_i
// set parks the fetch side until l_lock_i is sampled low. Read data (1-cycle
// latency) is routed to whichever requester issued the read.
// Optional feature: define IMEM_ARB_PERF_EN to add the perf_* counter ports.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   f_req_i/f_addr_i                  : fetch read request and word address
//   f_gnt_o/f_rvalid_o/f_rdata_o      : fetch grant, read-data valid, read data
//   l_req_i/l_we_i/l_addr_i/l_wdata_i : loader request, write enable, address, data
//   l_lock_i                          : loader wants exclusive ownership of the port
//   l_gnt_o/l_rvalid_o/l_rdata_o      : loader grant, read-data valid, read data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i : memory port
//   perf_fetch_o/perf_load_o/perf_stall_o : counters (IMEM_ARB_PERF_EN only)
module imem_port_arbiter
   import types_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             f_req_i,
   input  address_t         f_addr_i,
   output logic             f_gnt_o,
   output logic             f_rvalid_o,
   output word_t            f_rdata_o,
   input  logic             l_req_i,
   input  logic             l_we_i,
   input  address_t         l_addr_i,
   input  word_t            l_wdata_i,
   input  logic             l_lock_i,
   output logic             l_gnt_o,
   output logic             l_rvalid_o,
   output word_t            l_rdata_o,
   output logic             mem_en_o,
   output logic             mem_we_o,
   output address_t         mem_addr_o,
   output word_t            mem_wdata_o,
`ifdef IMEM_ARB_PERF_EN
   output logic [CNT_W-1:0] perf_fetch_o,
   output logic [CNT_W-1:0] perf_load_o,
   output logic [CNT_W-1:0] perf_stall_o,
`endif
   input  word_t            mem_rdata_i
);

   if (STARVE_LIMIT < 1) begin : gen_chk_starve
      $error("imem_port_arbiter: STARVE_LIMIT must be >= 1");
   end
   if (CNT_W < 1) begin : gen_chk_cnt
      $error("imem_port_arbiter: CNT_W must be >= 1");
   end

   localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);
   localparam logic [StW-1:0] StarveMax = StW'(STARVE_LIMIT);

   arb_state_e  state_q, state_d;
   imem_owner_e owner_q, owner_d;
   logic [StW-1:0] starve_q, starve_d;
   word_t       f_hold_q, l_hold_q;
   logic        starve_hit;

   assign starve_hit = (starve_q == StarveMax);

   // Grants are gated by rst_n so nothing reaches the memory while in reset.
   always_comb begin
      f_gnt_o = 1'b0;
      l_gnt_o = 1'b0;
      if (rst_n) begin
         if (state_q == S_LOCK) begin
            l_gnt_o = l_req_i;
         end else begin
            l_gnt_o = l_req_i && (!f_req_i || starve_hit);
            f_gnt_o = f_req_i && !l_gnt_o;
         end
      end
   end

   always_comb begin
      mem_en_o    = f_gnt_o | l_gnt_o;
      mem_we_o    = l_gnt_o & l_we_i;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (l_gnt_o) begin
         mem_addr_o  = l_addr_i;
         mem_wdata_o = l_wdata_i;
      end else if (f_gnt_o) begin
         mem_addr_o  = f_addr_i;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = OWN_NONE;
      starve_d = starve_q;

      if (f_gnt_o)                owner_d = OWN_FETCH;
      else if (l_gnt_o && !l_we_i) owner_d = OWN_LOAD;

      if (!l_req_i || l_gnt_o)    starve_d = '0;
      else if (!starve_hit)       starve_d = starve_q + 1'b1;

      unique case (state_q)
         S_SHARED: if (l_gnt_o && l_lock_i) state_d = S_LOCK;
         S_LOCK:   if (!l_lock_i)           state_d = S_SHARED;
         default:                           state_d = S_SHARED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_SHARED;
         owner_q  <= OWN_NONE;
         starve_q <= '0;
         f_hold_q <= '0;
         l_hold_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         if (owner_q == OWN_FETCH) f_hold_q <= mem_rdata_i;
         if (owner_q == OWN_LOAD)  l_hold_q <= mem_rdata_i;
      end
   end

   // The owner sees live memory data; the other side keeps its last word.
   assign f_rvalid_o = (owner_q == OWN_FETCH);
   assign l_rvalid_o = (owner_q == OWN_LOAD);
   assign f_rdata_o  = f_rvalid_o ? mem_rdata_i : f_hold_q;
   assign l_rdata_o  = l_rvalid_o ? mem_rdata_i : l_hold_q;

`ifdef IMEM_ARB_PERF_EN
   imem_arb_perf #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk          (clk),
      .rst_n        (rst_n),
      .f_gnt_i      (f_gnt_o),
      .l_gnt_i      (l_gnt_o),
      .stall_i      (f_req_i && !f_gnt_o),
      .perf_fetch_o (perf_fetch_o),
      .perf_load_o  (perf_load_o),
      .perf_stall_o (perf_stall_o)
   );
`endif

endmodule
